// File: rtl/upsizer_w_packer_if.sv
// rtl/upsizer_w_packer_if.sv - command, narrow FIFO read side and wide W channel of the upsizer W packer
// master is the packer side; slave is the surrounding AW logic, FIFO and wide slave port.
interface upsizer_w_packer_if #(
  parameter int NARROW_WIDTH = 32,
  parameter int WIDE_WIDTH   = 128,
  parameter int LEN_WIDTH    = 8
);
  localparam int RATIO  = WIDE_WIDTH / NARROW_WIDTH;
  localparam int LANE_W = $clog2(RATIO);

  logic                                 cmd_valid_i;
  logic                                 cmd_ready_o;
  logic [LANE_W-1:0]                    cmd_lane_i;
  logic [LEN_WIDTH-1:0]                 cmd_len_i;
  logic [NARROW_WIDTH+NARROW_WIDTH/8-1:0] fifo_data_i;
  logic                                 fifo_empty_i;
  logic                                 fifo_rd_o;
  logic [WIDE_WIDTH-1:0]                m_wdata_o;
  logic [WIDE_WIDTH/8-1:0]              m_wstrb_o;
  logic                                 m_wlast_o;
  logic                                 m_wvalid_o;
  logic                                 m_wready_i;

  modport master (
    input  cmd_valid_i, cmd_lane_i, cmd_len_i, fifo_data_i, fifo_empty_i, m_wready_i,
    output cmd_ready_o, fifo_rd_o, m_wdata_o, m_wstrb_o, m_wlast_o, m_wvalid_o
  );

  modport slave (
    output cmd_valid_i, cmd_lane_i, cmd_len_i, fifo_data_i, fifo_empty_i, m_wready_i,
    input  cmd_ready_o, fifo_rd_o, m_wdata_o, m_wstrb_o, m_wlast_o, m_wvalid_o
  );
endinterface

// File: rtl/upsizer_w_packer.sv
// rtl/upsizer_w_packer.sv - packs narrow W beats from the narrow FIFO into wide W beats
// Optional backpressure stall counter enabled by UPSZ_PACK_STALL_CNT_EN.
module upsizer_w_packer #(
  parameter int NARROW_WIDTH = 32,
  parameter int WIDE_WIDTH   = 128,
  parameter int LEN_WIDTH    = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  upsizer_w_packer_if.master   bus,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);
  localparam int RATIO  = WIDE_WIDTH / NARROW_WIDTH;
  localparam int LANE_W = $clog2(RATIO);
  localparam int NS     = NARROW_WIDTH / 8;
  localparam int WS     = WIDE_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [WIDE_WIDTH-1:0] data_q, data_d;
  logic [WS-1:0]        strb_q, strb_d;
  logic                 last_q, last_d;

  logic                 cmd_ready;
  logic                 pop;
  logic                 wvalid;
  logic [NARROW_WIDTH-1:0] head_data;
  logic [NS-1:0]        head_strb;

  assign head_data = bus.fifo_data_i[NARROW_WIDTH-1:0];
  assign head_strb = bus.fifo_data_i[NARROW_WIDTH +: NS];

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    rem_d     = rem_q;
    data_d    = data_q;
    strb_d    = strb_q;
    last_d    = last_q;
    cmd_ready = 1'b0;
    pop       = 1'b0;
    wvalid    = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid_i) begin
          lane_d  = bus.cmd_lane_i;
          rem_d   = bus.cmd_len_i;
          data_d  = '0;
          strb_d  = '0;
          last_d  = 1'b0;
          state_d = PACK;
        end
      end
      PACK: begin
        pop = !bus.fifo_empty_i;
        if (pop) begin
          data_d[lane_q*NARROW_WIDTH +: NARROW_WIDTH] = head_data;
          strb_d[lane_q*NS +: NS]                     = head_strb;
          lane_d = lane_q + 1'b1;
          // remaining stops at zero; the zero case always closes the burst
          if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
          end
          if (lane_q == LANE_W'(RATIO - 1) || rem_q == '0) begin
            last_d  = (rem_q == '0);
            state_d = SEND;
          end
        end
      end
      SEND: begin
        wvalid = 1'b1;
        if (bus.m_wready_i) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            data_d  = '0;
            strb_d  = '0;
            lane_d  = '0;
            state_d = PACK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
    end
  end

`ifdef UPSZ_PACK_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (wvalid && !bus.m_wready_i && stall_q != '1) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign bus.cmd_ready_o = cmd_ready;
  assign bus.fifo_rd_o   = pop;
  assign bus.m_wvalid_o  = wvalid;
  assign bus.m_wdata_o   = data_q;
  assign bus.m_wstrb_o   = strb_q;
  assign bus.m_wlast_o   = last_q;
  assign busy_o          = (state_q != IDLE);
endmodule

// File: tb/tb_upsizer_w_packer.sv
// tb/tb_upsizer_w_packer.sv - randomized self-checking bench for upsizer_w_packer
// Build with UPSZ_PACK_STALL_CNT_EN defined to also check the stall counter.
module tb_upsizer_w_packer;
  localparam int NW    = 32;
  localparam int WW    = 128;
  localparam int LW    = 8;
  localparam int CW    = 16;
  localparam int RATIO = WW / NW;

  typedef struct {
    logic [WW-1:0]   d;
    logic [WW/8-1:0] s;
    logic            l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic [CW-1:0] stall_cnt;

  upsizer_w_packer_if #(.NARROW_WIDTH(NW), .WIDE_WIDTH(WW), .LEN_WIDTH(LW)) bus ();

  upsizer_w_packer #(
    .NARROW_WIDTH(NW), .WIDE_WIDTH(WW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy_o(busy), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [NW+NW/8-1:0] fq[$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  bit    close_q[$];
  beat_t prev_b;
  int    n_checks = 0, n_pass = 0;
  int    pops, stall_model, cyc, acc_cyc;
  bit    cmd_pending, expect_valid, stalled_prev;
  int    cur_lane, cur_len, blk, hold_left, starve_at_g, starve_left;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int exp_stall();
`ifdef UPSZ_PACK_STALL_CNT_EN
    return (stall_model > 65535) ? 65535 : stall_model;
`else
    return 0;
`endif
  endfunction

  task automatic cycle();
    bit starve;
    @(negedge clk);
    starve = (starve_left > 0) && (pops >= starve_at_g) && !cmd_pending;
    bus.cmd_valid_i  = cmd_pending;
    bus.cmd_lane_i   = 2'(cur_lane);
    bus.cmd_len_i    = 8'(cur_len);
    bus.fifo_empty_i = starve || (fq.size() == 0);
    bus.fifo_data_i  = (fq.size() != 0) ? fq[0] : '0;
    if (bus.m_wvalid_o && hold_left > 0) begin
      bus.m_wready_i = 1'b0;
      hold_left--;
    end else begin
      bus.m_wready_i = ($urandom_range(99) >= blk);
    end
    #1;
    cyc++;
    if (starve) starve_left--;
    if (expect_valid) check("wvalid_after_close", bus.m_wvalid_o, 1);
    expect_valid = 0;
    if (stalled_prev) begin
      check("hold_valid", bus.m_wvalid_o, 1);
      check("hold_data", bus.m_wdata_o, prev_b.d);
      check("hold_strb", bus.m_wstrb_o, prev_b.s);
      check("hold_last", bus.m_wlast_o, prev_b.l);
    end
    check("cmd_ready_vs_busy", bus.cmd_ready_o, !busy);
    if (bus.m_wvalid_o) check("no_pop_in_send", bus.fifo_rd_o, 0);
    if (bus.fifo_empty_i) check("no_pop_when_empty", bus.fifo_rd_o, 0);
    if (cyc == acc_cyc + 1) check("first_pop_latency", bus.fifo_rd_o, !bus.fifo_empty_i);
    if (cmd_pending && bus.cmd_ready_o) begin
      cmd_pending = 0;
      acc_cyc = cyc;
    end
    if (bus.fifo_rd_o && fq.size() != 0) begin
      void'(fq.pop_front());
      pops++;
      if (close_q.size() != 0) expect_valid = close_q.pop_front();
    end
    if (bus.m_wvalid_o && bus.m_wready_i) begin
      beat_t o;
      o.d = bus.m_wdata_o; o.s = bus.m_wstrb_o; o.l = bus.m_wlast_o;
      obs_q.push_back(o);
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("wdata", o.d, e.d);
        check("wstrb", o.s, e.s);
        check("wlast", o.l, e.l);
      end
    end
    if (bus.m_wvalid_o && !bus.m_wready_i) begin
      stall_model++;
      stalled_prev = 1;
      prev_b.d = bus.m_wdata_o; prev_b.s = bus.m_wstrb_o; prev_b.l = bus.m_wlast_o;
    end else begin
      stalled_prev = 0;
    end
  endtask

  // Reference: narrow beat i lands in lane (lane+i) mod RATIO of wide beat (lane+i)/RATIO.
  task automatic load_burst(input int lane, input int len, input bit directed,
                            input int block_pct, input int hold, input int s_at, input int s_len);
    beat_t b;
    int    widx, last_widx;
    last_widx = (lane + len) / RATIO;
    for (int w = 0; w <= last_widx; w++) begin
      b.d = '0; b.s = '0; b.l = (w == last_widx);
      exp_q.push_back(b);
    end
    for (int i = 0; i <= len; i++) begin
      logic [NW-1:0] dd;
      logic [3:0]    ss;
      int            slot;
      if (directed) begin
        dd = {4{8'((i + 1) * 17)}};
        ss = 4'hF;
      end else begin
        dd = $urandom;
        ss = 4'($urandom_range(15));
      end
      fq.push_back({ss, dd});
      widx = (lane + i) / RATIO;
      slot = (lane + i) % RATIO;
      exp_q[widx].d[slot*NW +: NW] = dd;
      exp_q[widx].s[slot*4 +: 4]   = ss;
      close_q.push_back((slot == RATIO - 1) || (i == len));
    end
    obs_q.delete();
    cur_lane = lane; cur_len = len; blk = block_pct; hold_left = hold;
    starve_at_g = s_at; starve_left = s_len; pops = 0; cmd_pending = 1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    do begin
      cycle();
      guard++;
    end while ((cmd_pending || exp_q.size() != 0 || busy) && guard < 4000);
    check("burst_done", guard < 4000, 1);
    check("fifo_drained", fq.size(), 0);
    check("stall_cnt", stall_cnt, exp_stall());
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, bus.cmd_ready_o, 1);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_fifo_rd"}, bus.fifo_rd_o, 0);
    check({pfx, "_wvalid"}, bus.m_wvalid_o, 0);
    check({pfx, "_wlast"}, bus.m_wlast_o, 0);
    check({pfx, "_wdata"}, bus.m_wdata_o, 0);
    check({pfx, "_wstrb"}, bus.m_wstrb_o, 0);
    check({pfx, "_stall"}, stall_cnt, 0);
  endtask

  initial begin
    int guard;
    bus.cmd_valid_i = 0; bus.cmd_lane_i = 0; bus.cmd_len_i = 0;
    bus.fifo_data_i = 0; bus.fifo_empty_i = 1; bus.m_wready_i = 0;
    stall_model = 0; cyc = 0; acc_cyc = -10; cmd_pending = 0;
    expect_valid = 0; stalled_prev = 0; pops = 0;
    cur_lane = 0; cur_len = 0; blk = 0; hold_left = 0; starve_at_g = 0; starve_left = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1;

    load_burst(0, 3, 1, 0, 0, 0, 0);
    drain();
    check("aligned_data", obs_q[0].d, 128'h44444444_33333333_22222222_11111111);
    check("aligned_strb", obs_q[0].s, 16'hFFFF);
    check("aligned_beats", obs_q.size(), 1);

    load_burst(2, 3, 1, 0, 0, 0, 0);
    drain();
    check("unaligned_strb0", obs_q[0].s, 16'hFF00);
    check("unaligned_last0", obs_q[0].l, 0);
    check("unaligned_strb1", obs_q[1].s, 16'h00FF);
    check("unaligned_last1", obs_q[1].l, 1);

    load_burst(0, 3, 1, 0, 5, 0, 0);
    drain();
`ifdef UPSZ_PACK_STALL_CNT_EN
    check("stall_after_hold5", stall_cnt, 5);
`else
    check("stall_tied_zero", stall_cnt, 0);
`endif

    load_burst(0, 5, 1, 0, 0, 2, 3);
    drain();
    check("starve_strb1", obs_q[1].s, 16'h00FF);

    load_burst(3, 0, 1, 0, 0, 0, 0);
    drain();
    check("single_strb", obs_q[0].s, 16'hF000);
    check("single_last", obs_q[0].l, 1);

    load_burst(0, 7, 1, 0, 0, 0, 0);
    guard = 0;
    while (pops < 2 && guard < 50) begin
      cycle();
      guard++;
    end
    check("reached_two_pops", pops, 2);
    @(negedge clk);
    rst_n = 0;
    bus.cmd_valid_i = 0;
    bus.fifo_empty_i = 1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1;
    fq.delete(); exp_q.delete(); close_q.delete();
    stall_model = 0; expect_valid = 0; stalled_prev = 0; cmd_pending = 0;
    load_burst(1, 6, 1, 0, 0, 0, 0);
    drain();

    for (int k = 0; k < 40; k++) begin
      int len;
      len = (k == 20) ? 255 : int'($urandom_range(12));
      load_burst(int'($urandom_range(3)), len, 0, 30, int'($urandom_range(2)),
                 int'($urandom_range(len)), int'($urandom_range(3)));
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/upsizer_w_packer.md
Name: upsizer_w_packer

Overview:
- Write-data sequencer for the AXI upsizer. Pops narrow W beats from the upstream narrow-beat FIFO and packs them into wide W beats for the wide slave port.
- Per-burst command (start lane, beat count) comes from the AW-side address logic.
- Sits between the narrow W FIFO's read side and the wide W channel output. It owns that FIFO's pop strobe.

Parameters:
- NARROW_WIDTH, 32, narrow data width in bits (multiple of 8).
- WIDE_WIDTH, 128, wide data width in bits. Must equal RATIO*NARROW_WIDTH with RATIO a power of two, at least 2.
- LEN_WIDTH, 8, width of burst length field (AXI4 len).
- CNT_WIDTH, 16, width of optional stall counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid_i  in  1  burst command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_lane_i  in  log2(RATIO)  wide-beat lane of first narrow beat.
- cmd_len_i  in  LEN_WIDTH  narrow beats minus one.
- fifo_data_i  in  NARROW_WIDTH+NARROW_WIDTH/8  FIFO head entry, {strb, data}, valid while not empty.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rd_o  out  1  pop strobe to FIFO.
- m_wdata_o  out  WIDE_WIDTH  packed wide data.
- m_wstrb_o  out  WIDE_WIDTH/8  packed wide strobes.
- m_wlast_o  out  1  last wide beat of burst.
- m_wvalid_o  out  1  wide beat valid.
- m_wready_i  in  1  wide beat ready.
- busy_o  out  1  burst in progress (state != IDLE).
- stall_cnt_o  out  CNT_WIDTH  backpressure cycle count (optional feature).

Behaviour:
- States: IDLE, PACK, SEND.
- Reset (rst_n=0 at clk edge): state=IDLE; lane, remaining count and data/strb accumulators cleared to 0. Outputs after reset:
  - cmd_ready_o=1, busy_o=0.
  - fifo_rd_o=0.
  - m_wvalid_o=0, m_wlast_o=0, m_wdata_o=0, m_wstrb_o=0.
  - stall_cnt_o=0.
- Reset mid-burst aborts the burst. No partial beat is emitted, and FIFO contents are left as-is.
- IDLE:
  - cmd_ready_o=1 (combinational from state).
  - On cmd_valid_i: latch lane=cmd_lane_i and remaining=cmd_len_i; clear accumulators; go to PACK next cycle.
- PACK:
  - fifo_rd_o = !fifo_empty_i (combinational). An empty FIFO stalls with no state change.
  - Each pop writes fifo_data_i into accumulator lane `lane`: data bits [lane*NW +: NW], strb bits [lane*NW/8 +: NW/8].
  - On each pop, lane increments modulo RATIO and remaining decrements.
  - Close condition on a pop: lane==RATIO-1 or remaining==0. Then go to SEND next cycle; wlast register = (remaining==0).
  - Unwritten lanes keep strb 0 and data 0.
- SEND:
  - m_wvalid_o=1, with data/strb/last held stable from registers until m_wready_i.
  - fifo_rd_o=0. No popping during SEND.
  - On m_wvalid_o&m_wready_i:
    - if wlast: go to IDLE.
    - else: clear accumulators, set lane=0, go to PACK.
- Latency:
  - First pop occurs the cycle after command acceptance.
  - m_wvalid_o rises the cycle after the closing pop.
  - Peak throughput is one wide beat per (beats packed + 1) cycles.
- A command arriving while busy waits (cmd_ready_o=0).
- remaining counts LEN_WIDTH bits; len=255 is legal. No wrap handling is needed since the count only decrements to 0.
- A start lane near the top yields a short first wide beat. A burst ending mid-beat yields a short last beat with partial strobes.

Optional Feature:
- Macro UPSZ_PACK_STALL_CNT_EN.
- Defined:
  - stall_cnt_o increments by 1 on each cycle with m_wvalid_o=1 and m_wready_i=0.
  - Saturates at all-ones and clears only on reset.
- Undefined: no counter register; stall_cnt_o tied to 0.
- All other behaviour is identical either way.

Test Plan:
All cases use RATIO=4 and NW=32.
- Aligned full burst: cmd lane=0 len=3; FIFO holds 0x11..,0x22..,0x33..,0x44.. with strb 0xF → one wide beat, data {44,33,22,11}, strb 0xFFFF, wlast=1; then back to IDLE with cmd_ready_o=1.
- Unaligned burst: cmd lane=2 len=3 →
  - beat0: strb 0xFF00, wlast=0.
  - beat1: strb 0x00FF, wlast=1.
  - Lanes hold the FIFO entries in order.
- Backpressure: hold m_wready_i=0 for 5 cycles during SEND → outputs stable, fifo_rd_o=0. With UPSZ_PACK_STALL_CNT_EN, stall_cnt_o=5.
- FIFO starvation: fifo_empty_i=1 for 3 cycles mid-PACK → fifo_rd_o=0, lane and remaining unchanged; packing resumes correctly when the FIFO refills.
- Single-beat burst: cmd lane=3 len=0 → one wide beat, strb 0xF000, wlast=1.
- Reset mid-operation: assert rst_n=0 during PACK after 2 pops → next cycle all outputs at reset values and state IDLE. A new command then completes normally.
